// File: rtl/mag_cordic_pkg.sv
// Shared definitions for the iterative CORDIC magnitude engine: FSM state
// encoding, default datapath width, default gain constant and the helper
// that sizes the iteration counter.
package mag_cordic_pkg;

    localparam int DIN_W        = 24;
    localparam int IW_DEF       = 26;
    localparam int NUM_ITER_DEF = 16;
    // 1/1.646760 scaled by 2^17 (unsigned Q0.17)
    localparam int K_GAIN_DEF   = 79594;
    localparam int GAIN_FRAC    = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_GAIN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Width of the iteration counter; a single-iteration build still needs one bit.
    function automatic int iter_cnt_width(input int num_iter);
        int w;
        if (num_iter > 1) begin
            w = $clog2(num_iter);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mag_rot_var.sv
// One CORDIC vectoring micro-rotation with a run-time shift amount.
// The rotation direction drives y toward zero; the shift is a log-depth
// barrel arithmetic shifter so the same stage serves every iteration.
module mag_rot_var
    import mag_cordic_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int KW = 4
) (
    input  logic signed [IW-1:0] x,
    input  logic signed [IW-1:0] y,
    input  logic        [KW-1:0] k,
    output logic signed [IW-1:0] x_next,
    output logic signed [IW-1:0] y_next
);

    logic signed [IW-1:0] x_shift_s;
    logic signed [IW-1:0] y_shift_s;

    // Barrel arithmetic shifter: stage b shifts by 2^b when bit b of k is set.
    always_comb begin
        x_shift_s = x;
        y_shift_s = y;
        for (int b = 0; b < KW; b++) begin
            if (k[b]) begin
                x_shift_s = x_shift_s >>> (2 ** b);
                y_shift_s = y_shift_s >>> (2 ** b);
            end else begin
                x_shift_s = x_shift_s;
                y_shift_s = y_shift_s;
            end
        end
    end

    // Rotate toward the positive x axis: direction chosen by the sign of y.
    always_comb begin
        x_next = x;
        y_next = y;
        if (y[IW-1]) begin
            x_next = x - y_shift_s;
            y_next = y + x_shift_s;
        end else begin
            x_next = x + y_shift_s;
            y_next = y - x_shift_s;
        end
    end

endmodule

// File: rtl/mag_cordic_seq.sv
// Iterative CORDIC magnitude engine: |i + jq| for a 24-bit signed sample.
// One shared rotation stage is reused for NUM_ITER cycles, then the CORDIC
// gain is removed with a single multiply and the result is saturated to 24 bits.
// Valid/ready on both sides; one sample in flight at a time.
module mag_cordic_seq
    import mag_cordic_pkg::*;
#(
    parameter int NUM_ITER = NUM_ITER_DEF,
    parameter int IW       = IW_DEF,
    parameter int K_GAIN   = K_GAIN_DEF
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] i_in,
    input  logic [23:0] q_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] mag_out,
    output logic        busy
);

    localparam int              KW        = iter_cnt_width(NUM_ITER);
    localparam int              PW        = IW + 18;
    localparam logic [KW-1:0]   ITER_LAST = KW'(NUM_ITER - 1);
    localparam logic [KW-1:0]   CNT_ONE   = KW'(1);
    localparam logic [PW-1:0]   K_GAIN_W  = PW'(K_GAIN);
    localparam logic [PW-1:0]   SAT_MAX   = PW'(24'hFFFFFF);

    state_e               state_r;
    logic signed [IW-1:0] x_r;
    logic signed [IW-1:0] y_r;
    logic        [KW-1:0] iter_cnt_r;

    logic signed [IW-1:0] i_ext_s;
    logic signed [IW-1:0] q_ext_s;
    logic signed [IW-1:0] i_abs_s;
    logic signed [IW-1:0] x_next_s;
    logic signed [IW-1:0] y_next_s;
    logic        [PW-1:0] prod_s;
    logic        [PW-1:0] m_s;
    logic        [23:0]   mag_sat_s;

    // Widen the inputs; |i| is taken after widening so -2^23 negates cleanly.
    always_comb begin
        i_ext_s = {{(IW-DIN_W){i_in[DIN_W-1]}}, i_in};
        q_ext_s = {{(IW-DIN_W){q_in[DIN_W-1]}}, q_in};
        if (i_in[DIN_W-1]) begin
            i_abs_s = -i_ext_s;
        end else begin
            i_abs_s = i_ext_s;
        end
    end

    mag_rot_var #(
        .IW (IW),
        .KW (KW)
    ) u_rot (
        .x      (x_r),
        .y      (y_r),
        .k      (iter_cnt_r),
        .x_next (x_next_s),
        .y_next (y_next_s)
    );

    // Gain correction: unsigned x times K in Q0.17, drop the fraction, saturate.
    always_comb begin
        prod_s = PW'($unsigned(x_r)) * K_GAIN_W;
        m_s    = prod_s >> GAIN_FRAC;
        if (m_s > SAT_MAX) begin
            mag_sat_s = 24'hFFFFFF;
        end else begin
            mag_sat_s = m_s[23:0];
        end
    end

    // Control FSM with the working registers and all registered outputs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r    <= ST_IDLE;
            x_r        <= {IW{1'b0}};
            y_r        <= {IW{1'b0}};
            iter_cnt_r <= {KW{1'b0}};
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            mag_out    <= 24'd0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        x_r        <= i_abs_s;
                        y_r        <= q_ext_s;
                        iter_cnt_r <= {KW{1'b0}};
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= ST_ITER;
                    end else begin
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    x_r        <= x_next_s;
                    y_r        <= y_next_s;
                    iter_cnt_r <= iter_cnt_r + CNT_ONE;
                    if (iter_cnt_r == ITER_LAST) begin
                        state_r <= ST_GAIN;
                    end else begin
                        state_r <= ST_ITER;
                    end
                end
                ST_GAIN: begin
                    mag_out   <= mag_sat_s;
                    out_valid <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    x_r        <= {IW{1'b0}};
                    y_r        <= {IW{1'b0}};
                    iter_cnt_r <= {KW{1'b0}};
                    in_ready   <= 1'b1;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_cordic_seq.sv
// Scoreboard bench for mag_cordic_seq: the driver pushes each accepted sample,
// a monitor pops on every output handshake and compares against sqrt(i^2+q^2).
module tb_mag_cordic_seq;

    localparam int NUM_ITER = 16;
    localparam int N_RAND   = 2000;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] i_in = 24'd0;
    logic [23:0] q_in = 24'd0;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] mag_out;
    logic        busy;

    typedef struct { int i; int q; } sample_t;
    sample_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    int edges;
    bit stall = 1'b0;
    logic [23:0] held;
    logic [23:0] rnd_i, rnd_q;
    sample_t popped;

    always #5 clk = ~clk;

    mag_cordic_seq #(.NUM_ITER(NUM_ITER)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_in      (i_in),
        .q_in      (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .busy      (busy)
    );

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_mag(input sample_t s, input logic [23:0] got);
        real ex, tol, d;
        ex  = $sqrt(real'(s.i) * real'(s.i) + real'(s.q) * real'(s.q));
        tol = (s.i == 0 && s.q == 0) ? 0.0 : 4.0 + ex / 65536.0;
        d   = real'(got) - ex;
        if (d < 0.0) d = -d;
        total++;
        if (d > tol) begin
            bad++;
            $display("FAIL mag i=%0d q=%0d: got %0d expected %0.2f +/- %0.2f", s.i, s.q, got, ex, tol);
        end
    endtask

    // Offer a sample and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic send(input int iv, input int qv);
        int waited;
        sample_t s;
        @(posedge clk); #1;
        i_in = 24'(iv);
        q_in = 24'(qv);
        in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                chk(1'b0, "accept_timeout", waited, 200);
                in_valid = 1'b0;
                return;
            end
        end
        s.i = iv;
        s.q = qv;
        exp_q.push_back(s);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && exp_q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(n < 300, "idle_timeout", n, 300);
    endtask

    // Sink readiness driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares on every output handshake and checks hold behaviour under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                stall = 1'b0;
            end else if (out_valid) begin
                if (stall) chk(mag_out == held, "hold_stable", mag_out, held);
                chk(in_ready == 1'b0, "in_ready_low_while_output", in_ready, 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_output", mag_out, 0);
                    end else begin
                        popped = exp_q.pop_front();
                        check_mag(popped, mag_out);
                    end
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    held  = mag_out;
                end
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        chk(mag_out == 24'd0, "reset_mag_out", mag_out, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        @(negedge clk);
        reset_b = 1'b1;

        // 3-4-5 triangle with latency and busy checks
        ready_mode = 0;
        send(3000000, 4000000);
        edges = 0;
        while (!out_valid && edges < 64) begin
            chk(busy == 1'b1, "busy_during_op", busy, 1);
            @(posedge clk); #1;
            edges++;
        end
        chk(edges == NUM_ITER + 1, "latency", edges, NUM_ITER + 1);
        wait_idle();

        // Corner cases
        send(-8388608, 0);
        send(0, -8388608);
        send(0, 0);
        send(-5932000, -5932000);
        wait_idle();

        // Backpressure: output held for 20 cycles while the next sample waits
        ready_mode = 1;
        send(2500000, -1200000);
        edges = 0;
        while (!out_valid && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
        chk(out_valid == 1'b1, "bp_output_seen", out_valid, 1);
        fork
            begin
                repeat (20) begin
                    @(negedge clk);
                    chk(out_valid == 1'b1, "bp_valid_held", out_valid, 1);
                    chk(busy == 1'b1, "bp_busy", busy, 1);
                end
                ready_mode = 0;
            end
            begin
                send(-700000, 3100000);
            end
        join
        wait_idle();

        // Reset in the middle of iteration 5 abandons the sample
        send(20000, 30000);
        repeat (5) @(posedge clk);
        #1;
        reset_b = 1'b0;
        #1;
        chk(in_ready == 1'b1, "midreset_in_ready", in_ready, 1);
        chk(out_valid == 1'b0, "midreset_out_valid", out_valid, 0);
        chk(mag_out == 24'd0, "midreset_mag_out", mag_out, 0);
        chk(busy == 1'b0, "midreset_busy", busy, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        reset_b = 1'b1;
        repeat (NUM_ITER + 8) begin
            @(negedge clk);
            chk(out_valid == 1'b0, "no_output_after_reset", out_valid, 0);
        end
        send(1000, 0);
        wait_idle();

        // Random samples with random sink readiness
        ready_mode = 2;
        for (int n = 0; n < N_RAND; n++) begin
            rnd_i = 24'($urandom);
            rnd_q = 24'($urandom);
            send(int'($signed(rnd_i)), int'($signed(rnd_q)));
        end
        ready_mode = 0;
        wait_idle();
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
